led_dir_ctrl: RTL and testbench

//  Input-side companion of the LED up/down counter. Converts two raw push-buttons into the

---
 rtl/led_dir_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_led_dir_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_dir_ctrl.sv
// ---------------------------------------------------------------------------
// Module : led_dir_ctrl
//
// Input-side companion of the LED up/down counter. Two raw push-buttons are
// synchronised, debounced and then arbitrated by a small FSM. The outputs
// drive the counter: a registered direction level and a one-cycle step pulse.
//
// Optional feature (compile-time macro AUTO_REPEAT_EN):
//   When defined, a button that stays held keeps producing step pulses. The
//   first repeat comes REPEAT_DELAY cycles after the initial step, and later
//   repeats come every REPEAT_PERIOD cycles. When the macro is undefined,
//   each press gives exactly one step and the repeat parameters are ignored.
//
// Parameters
//   DB_CYCLES      consecutive stable cycles before a debounced level flips
//   REPEAT_DELAY   hold time before auto-repeat starts (AUTO_REPEAT_EN only)
//   REPEAT_PERIOD  spacing of repeated steps           (AUTO_REPEAT_EN only)
//   DIR_RESET      direction after reset (1 = up, 0 = down)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   btn_up     in   raw up button, asynchronous, 1 = pressed
//   btn_down   in   raw down button, asynchronous, 1 = pressed
//   direction  out  registered direction to counter (1 = up, 0 = down)
//   step       out  one-clock pulse requesting one count step
//   held       out  1 while the FSM is in HELD_UP or HELD_DN
// ---------------------------------------------------------------------------
module led_dir_ctrl #(
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter logic        DIR_RESET     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic direction,
  output logic step,
  output logic held
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);

  // The counter flips the level on the DB_CYCLES-th consecutive differing
  // cycle, so the compare value is one below DB_CYCLES.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD_UP = 2'd1,
    HELD_DN = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Bit 0 carries the up button and bit 1 carries the down button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync_1;
  logic [1:0]      sync_2;
  logic [1:0]      deb;
  logic [1:0]      deb_prev;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  state_t state;
  logic   own_level;
  logic   other_level;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_phase;
  logic [RPT_W-1:0] rpt_target;
`endif

  assign btn_raw = {btn_down, btn_up};

  // Two-flop synchroniser per button. The raw buttons are asynchronous to
  // clk, so nothing downstream may look at them before this point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 2'b00;
      sync_2 <= 2'b00;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Debounce per button. The counter runs only while the synchronised level
  // disagrees with the debounced one, so any bounce back to the old level
  // restarts the wait from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb       <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Previous debounced level, used to turn a rising level into a one-cycle
  // press event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_prev <= 2'b00;
    end else begin
      deb_prev <= deb;
    end
  end

  assign press = deb & ~deb_prev;

  // While held, own_level is the button that caused the hold and other_level
  // is the opposite button. The held states can then share one FSM branch.
  always_comb begin
    own_level   = 1'b0;
    other_level = 1'b0;
    if (state == HELD_UP) begin
      own_level   = deb[0];
      other_level = deb[1];
    end else if (state == HELD_DN) begin
      own_level   = deb[1];
      other_level = deb[0];
    end
  end

`ifdef AUTO_REPEAT_EN
  // The first repeat waits the long delay. After that the counter compares
  // against the shorter period.
  always_comb begin
    rpt_target = DELAY_LAST;
    if (rpt_phase) begin
      rpt_target = PERIOD_LAST;
    end
  end
`endif

  // Arbitration FSM with registered outputs. The direction is written only
  // on the edge that also raises step, so a direction change is always seen
  // together with its step. If both buttons are active at once, the FSM goes
  // to LOCKOUT. It stays there silently until both buttons are released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      direction <= DIR_RESET;
      step      <= 1'b0;
      held      <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
`endif
    end else begin
      step <= 1'b0;
`ifdef AUTO_REPEAT_EN
      // Outside an ongoing hold the repeat timer sits at zero. This clears it
      // on entry to a held state and again on leaving it.
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if ((press[0] && deb[1]) || (press[1] && deb[0])) begin
            state <= LOCKOUT;
            held  <= 1'b0;
          end else if (press[0]) begin
            state     <= HELD_UP;
            direction <= 1'b1;
            step      <= 1'b1;
            held      <= 1'b1;
          end else if (press[1]) begin
            state     <= HELD_DN;
            direction <= 1'b0;
            step      <= 1'b1;
            held      <= 1'b1;
          end
        end

        HELD_UP, HELD_DN: begin
          if (other_level) begin
            state <= LOCKOUT;
            held  <= 1'b0;
          end else if (!own_level) begin
            state <= IDLE;
            held  <= 1'b0;
          end
`ifdef AUTO_REPEAT_EN
          else begin
            rpt_phase <= rpt_phase;
            if (rpt_cnt == rpt_target) begin
              // Gating with the current step keeps pulses one cycle wide,
              // even if the period is set to a single cycle.
              step      <= ~step;
              rpt_cnt   <= '0;
              rpt_phase <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
`endif
        end

        LOCKOUT: begin
          held <= 1'b0;
          if (!deb[0] && !deb[1]) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_dir_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench : tb_led_dir_ctrl
// Directed self-checking bench for led_dir_ctrl with DB_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3 and DIR_RESET=1. Each input change is
// applied just after a rising edge, which counts as cycle 0. A clean press
// then shows its step on cycle 7.
// ---------------------------------------------------------------------------
module tb_led_dir_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic direction;
  logic step;
  logic held;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  led_dir_ctrl #(
    .DB_CYCLES    (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3),
    .DIR_RESET    (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .direction(direction),
    .step     (step),
    .held     (held)
  );

  // Advance one rising edge, then wait away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic up, input logic dn);
    btn_up   = up;
    btn_down = dn;
  endtask

  task automatic checkOutput(input string tag, input logic exp_dir,
                             input logic exp_step, input logic exp_held);
    n_checks++;
    assert (direction === exp_dir) else begin
      n_fail++;
      $error("[TB] FAIL %s direction got %b expected %b", tag, direction, exp_dir);
    end
    n_checks++;
    assert (step === exp_step) else begin
      n_fail++;
      $error("[TB] FAIL %s step got %b expected %b", tag, step, exp_step);
    end
    n_checks++;
    assert (held === exp_held) else begin
      n_fail++;
      $error("[TB] FAIL %s held got %b expected %b", tag, held, exp_held);
    end
  endtask

  // Run n cycles, expecting the same output values on every one of them.
  task automatic runCycles(input string tag, input int n, input logic exp_dir,
                           input logic exp_step, input logic exp_held);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag, exp_dir, exp_step, exp_held);
    end
  endtask

  initial begin
    logic exp_step;

    // 1. Reset values
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("reset", 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    runCycles("idle_after_reset", 3, 1'b1, 1'b0, 1'b0);

    // 2. Clean down press: step on cycle 7, then release
    $display("[TB] clean down press");
    applyStimulus(1'b0, 1'b1);
    runCycles("down_wait", 6, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("down_step", 1'b0, 1'b1, 1'b1);
    runCycles("down_hold", 13, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    runCycles("down_release_wait", 6, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("down_released", 1'b0, 1'b0, 1'b0);
    runCycles("down_idle", 2, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-hold; the button stays held through reset release
    $display("[TB] reset mid-hold");
    applyStimulus(1'b0, 1'b1);
    runCycles("pre_reset_wait", 6, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("pre_reset_step", 1'b0, 1'b1, 1'b1);
    runCycles("pre_reset_hold", 3, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #2;
    checkOutput("async_reset", 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("reset_mid_hold", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    runCycles("repress_wait", 6, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("repress_step", 1'b0, 1'b1, 1'b1);
    runCycles("repress_hold", 3, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    runCycles("repress_release_wait", 6, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("repress_released", 1'b0, 1'b0, 1'b0);

    // 4. Both buttons rise in the same cycle -> lockout
    $display("[TB] simultaneous press");
    applyStimulus(1'b1, 1'b1);
    runCycles("both_lockout", 12, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    runCycles("both_release", 10, 1'b0, 1'b0, 1'b0);

    // 3 + 6. Bouncing up press, then a long hold (auto-repeat if enabled)
    $display("[TB] bouncing up press and long hold");
    applyStimulus(1'b1, 1'b0);
    runCycles("bounce", 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    runCycles("bounce", 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    runCycles("bounce", 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    runCycles("bounce", 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    runCycles("bounce_settle", 6, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bounce_step", 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 36; k++) begin
      tick();
      exp_step = REPEAT_ON && (k >= 10) && (((k - 10) % 3) == 0);
      checkOutput($sformatf("hold_offset_%0d", k), 1'b1, exp_step, 1'b1);
      if (k == 30) begin
        applyStimulus(1'b0, 1'b0);
      end
    end
    tick();
    checkOutput("hold_released", 1'b1, 1'b0, 1'b0);
    runCycles("hold_idle", 2, 1'b1, 1'b0, 1'b0);

    // 5. Up held, down pressed 10 cycles later -> lockout
    $display("[TB] up then down lockout");
    applyStimulus(1'b1, 1'b0);
    runCycles("up_wait", 6, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("up_step", 1'b1, 1'b1, 1'b1);
    runCycles("up_hold", 3, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    runCycles("down_debounce", 6, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("enter_lockout", 1'b1, 1'b0, 1'b0);
    runCycles("lockout_hold", 5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    runCycles("lockout_up_released", 12, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    runCycles("lockout_both_released", 12, 1'b1, 1'b0, 1'b0);

    // Back in IDLE: a fresh down press steps normally
    applyStimulus(1'b0, 1'b1);
    runCycles("post_lockout_wait", 6, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("post_lockout_step", 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("post_lockout_hold", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    runCycles("post_lockout_release_wait", 6, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("post_lockout_released", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
